// File: rtl/gpio_apb_master_arb_pkg.sv
// Shared types and defaults for the two-port APB master in front of the gpio slave.
package gpio_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef logic req_id_t;

    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/gpio_apb_master_arb_rr_arb2.sv
// Two-way round-robin arbiter: a lone request always wins, a tie goes to prio.
module rr_arb2
    import gpio_apb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output req_id_t    gnt_id
);

    req_id_t prio;

    always_comb begin
        gnt_id = prio;
        if (req == 2'b01) begin
            gnt_id = 1'b0;
        end else if (req == 2'b10) begin
            gnt_id = 1'b1;
        end
        if (req == 2'b00) begin
            gnt = 2'b00;
        end else begin
            gnt = gnt_id ? 2'b10 : 2'b01;
        end
    end

    // After a grant the other requester gets the next tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (advance) begin
            prio <= ~gnt_id;
        end
    end

endmodule

// File: rtl/gpio_apb_master_arb.sv
// Shares the gpio APB slave between two requesters: round-robin grant, SETUP/ACCESS
// sequencing, PREADY timeout and per-requester response routing.
module gpio_apb_master_arb
    import gpio_apb_pkg::*;
#(
    parameter int GPIO_PINS  = 32,
    parameter int PADDR_SIZE = 4,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [2*PADDR_SIZE-1:0]    req_addr,
    input  logic [1:0]                 req_write,
    input  logic [2*GPIO_PINS-1:0]     req_wdata,
    input  logic [2*GPIO_PINS/8-1:0]   req_strb,
    output logic                       rsp_valid,
    output logic                       rsp_id,
    output logic [GPIO_PINS-1:0]       rsp_rdata,
    output logic                       rsp_err,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [PADDR_SIZE-1:0]      PADDR,
    output logic [GPIO_PINS-1:0]       PWDATA,
    output logic [GPIO_PINS/8-1:0]     PSTRB,
    input  logic                       PREADY,
    input  logic                       PSLVERR,
    input  logic [GPIO_PINS-1:0]       PRDATA
);

    localparam int STRB_W = GPIO_PINS / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_t             state;
    logic [CNT_W-1:0]       cnt;
    req_id_t                cur_id;
    logic [1:0]             gnt;
    req_id_t                gnt_id;
    logic                   take;
    logic [PADDR_SIZE-1:0]  sel_addr;
    logic                   sel_write;
    logic [GPIO_PINS-1:0]   sel_wdata;
    logic [STRB_W-1:0]      sel_strb;

    assign take      = (state == IDLE) && (req_valid != 2'b00) && !PRESET;
    assign req_ready = take ? gnt : 2'b00;

    rr_arb2 u_arb (
        .clk     (PCLK),
        .reset   (PRESET),
        .req     (req_valid),
        .advance (take),
        .gnt     (gnt),
        .gnt_id  (gnt_id)
    );

    assign sel_addr  = gnt_id ? req_addr[PADDR_SIZE +: PADDR_SIZE] : req_addr[0 +: PADDR_SIZE];
    assign sel_write = gnt_id ? req_write[1] : req_write[0];
    assign sel_wdata = gnt_id ? req_wdata[GPIO_PINS +: GPIO_PINS] : req_wdata[0 +: GPIO_PINS];
    assign sel_strb  = gnt_id ? req_strb[STRB_W +: STRB_W] : req_strb[0 +: STRB_W];

    // The ACCESS counter is one behind the cycle count, so cnt == TIMEOUT-1 is the last ACCESS cycle.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_id    <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        state   <= SETUP;
                        cnt     <= '0;
                        cur_id  <= gnt_id;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        PADDR   <= sel_addr;
                        PWRITE  <= sel_write;
                        PWDATA  <= sel_wdata;
                        PSTRB   <= sel_write ? sel_strb : '0;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    cnt <= cnt + CNT_W'(1);
                    if (PREADY || (cnt == CNT_LAST)) begin
                        state     <= IDLE;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                        // A late PREADY still counts as a normal completion.
                        rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
                        rsp_err   <= PREADY ? PSLVERR : 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_apb_master_arb.sv
// Bench for gpio_apb_master_arb: hand-written vector table, corner sequences and
// randomized transfers checked against a rule-based reference model.
module tb_gpio_apb_master_arb;

    localparam int TIMEOUT = 15;

    typedef struct {
        bit          both;
        int          id;
        bit          write;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] rdata;
        bit          slverr;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    logic        PCLK;
    logic        PRESET;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_addr;
    logic [1:0]  req_write;
    logic [63:0] req_wdata;
    logic [7:0]  req_strb;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] PRDATA;

    int          checks;
    int          errors;
    logic        m_prio;

    int          wait_cfg;
    logic [31:0] rdata_cfg;
    logic        err_cfg;
    int          acc_cnt;

    gpio_apb_master_arb #(
        .GPIO_PINS  (32),
        .PADDR_SIZE (4),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .PRDATA    (PRDATA)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Slave model: PREADY after wait_cfg extra ACCESS cycles.
    assign PREADY  = PSEL && PENABLE && (acc_cnt == wait_cfg);
    assign PRDATA  = rdata_cfg;
    assign PSLVERR = err_cfg && PREADY;

    always @(posedge PCLK) begin
        if (PRESET || !(PSEL && PENABLE) || PREADY) begin
            acc_cnt <= 0;
        end else begin
            acc_cnt <= acc_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference model: expected response derived from the slave behaviour and the timeout rule.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        bit   tmo;
        r         = v;
        tmo       = (v.waits >= TIMEOUT);
        r.exp_lat = tmo ? TIMEOUT + 2 : v.waits + 3;
        r.exp_rdata = (v.write || tmo) ? 32'h0 : v.rdata;
        r.exp_err = tmo || v.slverr;
        return r;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        int         gid;
        int         c;
        int         bad;
        logic [1:0] exp_ready;
        logic [3:0] exp_strb;
        gid       = v.both ? (m_prio ? 1 : 0) : v.id;
        wait_cfg  = v.waits;
        rdata_cfg = v.rdata;
        err_cfg   = v.slverr;
        @(posedge PCLK); #1;
        for (int i = 0; i < 2; i++) begin
            if (i == gid) begin
                req_addr[i*4 +: 4]   = v.addr;
                req_write[i]         = v.write;
                req_wdata[i*32 +: 32] = v.wdata;
                req_strb[i*4 +: 4]   = v.strb;
            end else begin
                req_addr[i*4 +: 4]   = ~v.addr;
                req_write[i]         = ~v.write;
                req_wdata[i*32 +: 32] = ~v.wdata;
                req_strb[i*4 +: 4]   = ~v.strb;
            end
        end
        req_valid = v.both ? 2'b11 : ((gid == 1) ? 2'b10 : 2'b01);
        #1;
        exp_ready = (gid == 1) ? 2'b10 : 2'b01;
        check_output("req_ready", req_ready, exp_ready);
        @(posedge PCLK); #1;
        req_valid = 2'b00;
        m_prio    = (gid == 0);
        exp_strb  = v.write ? v.strb : 4'h0;
        bad = 0;
        c   = 1;
        while (!rsp_valid && c <= 40) begin
            if (c < v.exp_lat) begin
                if (PSEL !== 1'b1 || PENABLE !== (c >= 2) || PADDR !== v.addr ||
                    PWRITE !== v.write || PWDATA !== v.wdata || PSTRB !== exp_strb) begin
                    bad++;
                end
            end
            @(posedge PCLK); #1;
            c++;
        end
        check_output("apb_phase", bad, 0);
        check_output("latency", c, v.exp_lat);
        check_output("rsp_valid", rsp_valid, 1);
        check_output("rsp_id", rsp_id, gid);
        check_output("rsp_rdata", rsp_rdata, v.exp_rdata);
        check_output("rsp_err", rsp_err, v.exp_err);
        check_output("idle_psel", {PSEL, PENABLE}, 0);
        @(posedge PCLK); #1;
        check_output("rsp_pulse", rsp_valid, 0);
        check_output("rsp_hold", rsp_rdata, v.exp_rdata);
    endtask

    task automatic check_all_zero(input string name);
        check_output(name, {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB}, 0);
        check_output({name, "_rsp"}, {rsp_valid, rsp_id, rsp_rdata, rsp_err}, 0);
    endtask

    vec_t tbl [8];
    vec_t v;
    int   gnt_ids  [$];
    int   gnt_cyc  [$];
    int   bad;

    initial begin
        checks    = 0;
        errors    = 0;
        m_prio    = 1'b0;
        wait_cfg  = 0;
        rdata_cfg = 32'h0;
        err_cfg   = 1'b0;
        acc_cnt   = 0;
        req_valid = 2'b00;
        req_addr  = '0;
        req_write = '0;
        req_wdata = '0;
        req_strb  = '0;

        //            both id  wr    addr   wdata          strb  waits rdata          slverr exp_rdata      err   lat
        tbl[0] = '{1'b0, 0, 1'b1, 4'h4, 32'hA5A5_0F0F, 4'hF, 0,  32'h0,         1'b0, 32'h0,         1'b0, 3};
        tbl[1] = '{1'b0, 1, 1'b0, 4'h0, 32'h0,         4'hF, 2,  32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 5};
        tbl[2] = '{1'b0, 0, 1'b0, 4'h8, 32'h0,         4'h0, 15, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b1, 17};
        tbl[3] = '{1'b0, 1, 1'b0, 4'hC, 32'h0,         4'h0, 0,  32'h0BAD_BEEF, 1'b0, 32'h0BAD_BEEF, 1'b0, 3};
        tbl[4] = '{1'b0, 1, 1'b0, 4'h4, 32'h0,         4'h0, 14, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 17};
        tbl[5] = '{1'b0, 1, 1'b1, 4'h2, 32'h1122_3344, 4'h3, 0,  32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0, 3};
        tbl[6] = '{1'b1, 0, 1'b1, 4'h9, 32'h0F0F_1234, 4'hC, 1,  32'h0,         1'b0, 32'h0,         1'b0, 4};
        tbl[7] = '{1'b0, 0, 1'b1, 4'h6, 32'h55AA_55AA, 4'h5, 1,  32'hFFFF_FFFF, 1'b1, 32'h0,         1'b1, 4};

        // Reset: all outputs zero, no ready even with both requesting.
        PRESET    = 1'b1;
        req_valid = 2'b11;
        repeat (3) @(posedge PCLK);
        #1;
        check_all_zero("reset");
        check_output("reset_ready", req_ready, 0);
        req_valid = 2'b00;
        PRESET    = 1'b0;
        m_prio    = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;

        // Both held valid: grants 0,1,0,1 spaced three cycles apart.
        wait_cfg  = 0;
        err_cfg   = 1'b0;
        req_addr  = 8'h31;
        req_write = 2'b11;
        req_wdata = {32'h1111_1111, 32'h0000_0000};
        req_strb  = 8'hFF;
        req_valid = 2'b11;
        #1;
        for (int cyc = 0; cyc < 20 && gnt_ids.size() < 4; cyc++) begin
            if (req_ready != 2'b00) begin
                gnt_ids.push_back((req_ready == 2'b10) ? 1 : 0);
                gnt_cyc.push_back(cyc);
            end
            @(posedge PCLK); #2;
        end
        req_valid = 2'b00;
        check_output("rr_count", gnt_ids.size(), 4);
        bad = 0;
        for (int k = 0; k < gnt_ids.size(); k++) begin
            if (gnt_ids[k] != (k % 2)) bad++;
            if (k > 0 && (gnt_cyc[k] - gnt_cyc[k-1]) != 3) bad++;
        end
        check_output("rr_order", bad, 0);
        m_prio = 1'b0;
        repeat (4) @(posedge PCLK);
        #1;

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(tbl[i]);
        end

        // Reset pulsed in ACCESS: transfer dropped, no response.
        wait_cfg  = 1000;
        req_addr  = 8'h0A;
        req_write = 2'b00;
        req_strb  = 8'h00;
        @(posedge PCLK); #1;
        req_valid = 2'b01;
        @(posedge PCLK); #1;
        req_valid = 2'b00;
        @(posedge PCLK); #1;
        check_output("mid_access", {PSEL, PENABLE}, 2'b11);
        PRESET    = 1'b1;
        req_valid = 2'b01;
        #1;
        check_output("mid_reset_ready", req_ready, 0);
        @(posedge PCLK); #1;
        check_all_zero("mid_reset");
        PRESET    = 1'b0;
        req_valid = 2'b00;
        m_prio    = 1'b0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge PCLK); #1;
            if (rsp_valid !== 1'b0) bad++;
        end
        check_output("mid_reset_no_rsp", bad, 0);

        // Randomized transfers against the reference model.
        for (int n = 0; n < 40; n++) begin
            v.both   = ($urandom_range(0, 3) == 0);
            v.id     = $urandom_range(0, 1);
            v.write  = 1'($urandom_range(0, 1));
            v.addr   = 4'($urandom);
            v.wdata  = $urandom;
            v.strb   = 4'($urandom);
            v.waits  = ($urandom_range(0, 4) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
            v.rdata  = $urandom;
            v.slverr = ($urandom_range(0, 4) == 0);
            apply_stimulus(model(v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
